// File: rtl/syncfifo_param.sv
// syncfifo_param: single-clock parametrised FIFO for same-domain buffering.
// It keeps the wpush/wfull and rpull/rempty handshake. It provides either a
// first-word-fall-through read or a registered read, plus an occupancy count,
// programmable almost-full/almost-empty thresholds, a synchronous flush, and
// sticky overflow/underflow error flags.
module syncfifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter bit FWFT       = 1'b1,
    parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wpush,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  almost_full,
    input  logic                  rpull,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  push_ok;
    logic                  pull_ok;

    // Status flags come only from the registered count, so there is no
    // combinational path from wpush or rpull to any flag.
    // NOTE: every output of an always_comb block is assigned on every path, so no latch is inferred.
    always_comb begin
        wfull        = (count == DEPTH_C);
        rempty       = (count == '0);
        almost_full  = (count >= AFULL_C);
        almost_empty = (count <= AEMPTY_C);
    end

    // A request is accepted only against the state before the edge. When the
    // FIFO is empty, a pull issued together with a push is therefore rejected.
    // When it is full, a push issued together with a pull is rejected.
    assign push_ok = wpush && !wfull;
    assign pull_ok = rpull && !rempty;

    // Pointers, occupancy and sticky error flags. Reset has priority over
    // flush, and flush has priority over push and pull.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pull_ok) rptr <= rptr + 1'b1;
            case ({push_ok, pull_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wpush && wfull)  overflow  <= 1'b1;
            if (rpull && rempty) underflow <= 1'b1;
        end
    end

    // Storage array. Reset and flush suppress the write, but the array is
    // never cleared.
    // NOTE: the memory has no reset so it can map onto RAM; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) mem[wptr] <= wdata;
    end

    generate
        if (FWFT) begin : g_fwft
            // The head word is visible as soon as it is stored. The output
            // reads zero while the FIFO is empty.
            assign rdata = rempty ? '0 : mem[rptr];
        end else begin : g_reg_read
            // Registered read: the popped word appears one cycle after the
            // pull edge and holds until the next accepted pull.
            always_ff @(posedge clk) begin
                if (rst || flush)  rdata <= '0;
                else if (pull_ok)  rdata <= mem[rptr];
            end
        end
    endgenerate

endmodule

// File: tb/tb_syncfifo_param.sv
// tb_syncfifo_param: scoreboard bench for syncfifo_param, with an FWFT
// instance for the main scenarios and a registered-read instance for the
// read-latency and mid-run reset scenario.
module tb_syncfifo_param;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT instance
    logic          rst = 1'b1, flush = 1'b0, wpush = 1'b0, rpull = 1'b0;
    logic [DW-1:0] wdata = '0, rdata;
    logic          wfull, almost_full, rempty, almost_empty, overflow, underflow;
    logic [AW:0]   count;

    // Registered-read instance
    logic          rst0 = 1'b1, flush0 = 1'b0, wpush0 = 1'b0, rpull0 = 1'b0;
    logic [DW-1:0] wdata0 = '0, rdata0;
    logic          wfull0, almost_full0, rempty0, almost_empty0, overflow0, underflow0;
    logic [AW:0]   count0;

    syncfifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wpush(wpush), .wdata(wdata),
        .wfull(wfull), .almost_full(almost_full), .rpull(rpull), .rdata(rdata),
        .rempty(rempty), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    syncfifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .flush(flush0), .wpush(wpush0), .wdata(wdata0),
        .wfull(wfull0), .almost_full(almost_full0), .rpull(rpull0), .rdata(rdata0),
        .rempty(rempty0), .almost_empty(almost_empty0), .count(count0),
        .overflow(overflow0), .underflow(underflow0)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model for the FWFT instance
    logic [DW-1:0] sb[$];
    int            mcount = 0;
    bit            movf   = 1'b0;
    bit            munf   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_status();
        check("count",        32'(count),        32'(mcount));
        check("wfull",        32'(wfull),        32'(mcount == DEPTH));
        check("almost_full",  32'(almost_full),  32'(mcount >= DEPTH - 2));
        check("rempty",       32'(rempty),       32'(mcount == 0));
        check("almost_empty", 32'(almost_empty), 32'(mcount <= 2));
        check("overflow",     32'(overflow),     32'(movf));
        check("underflow",    32'(underflow),    32'(munf));
        check("rdata_fwft",   rdata,             (mcount > 0) ? sb[0] : 32'h0);
    endtask

    // One clock cycle on the FWFT instance. Inputs are driven 1 time unit
    // after the edge, and the head word is compared before the pull edge.
    task automatic cycle(input bit push, input logic [DW-1:0] data, input bit pull);
        bit            pok;
        bit            lok;
        logic [DW-1:0] exp;
        pok   = push && (mcount < DEPTH);
        lok   = pull && (mcount > 0);
        wpush = push;
        wdata = data;
        rpull = pull;
        #1;
        if (lok) begin
            exp = sb.pop_front();
            check("rdata_pop", rdata, exp);
        end
        if (push && !pok) movf = 1'b1;
        if (pull && !lok) munf = 1'b1;
        if (pok) sb.push_back(data);
        mcount += int'(pok) - int'(lok);
        @(posedge clk);
        #1;
        wpush = 1'b0;
        rpull = 1'b0;
        check_status();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wpush = 1'b0;
        rpull = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        mcount = 0;
        movf   = 1'b0;
        munf   = 1'b0;
        check_status();
    endtask

    // Flush while a push and a pull are both requested. The flush wins, so
    // both requests are ignored.
    task automatic do_flush();
        flush = 1'b1;
        wpush = 1'b1;
        wdata = 32'hDEAD;
        rpull = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wpush = 1'b0;
        rpull = 1'b0;
        sb.delete();
        mcount = 0;
        check_status();
    endtask

    task automatic tick0();
        @(posedge clk);
        #1;
        wpush0 = 1'b0;
        rpull0 = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();

        // Fill with 2..17, then drain in order
        for (int v = 2; v <= 17; v++) cycle(1'b1, 32'(v), 1'b0);
        check("t1_wfull", 32'(wfull), 32'd1);
        check("t1_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
        check("t1_rempty", 32'(rempty), 32'd1);

        // Steady streaming at occupancy 3 with pointer wrap
        for (int v = 1; v <= 3; v++) cycle(1'b1, 32'(v), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 32'(20 + i), 1'b1);
        check("t4_count", 32'(count), 32'd3);
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_underflow", 32'(underflow), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

        // Full, with push and pull together: pull wins and push is dropped
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(100 + i), 1'b0);
        cycle(1'b1, 32'd99, 1'b1);
        check("t2_count", 32'(count), 32'd15);
        check("t2_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1);

        // Empty, with push and pull together: push wins and pull is rejected
        cycle(1'b1, 32'd7, 1'b1);
        check("t3_count", 32'(count), 32'd1);
        check("t3_underflow", 32'(underflow), 32'd1);
        check("t3_rdata", rdata, 32'd7);

        // Flush at occupancy 5; error flags must survive
        for (int v = 8; v <= 11; v++) cycle(1'b1, 32'(v), 1'b0);
        check("t5_pre_count", 32'(count), 32'd5);
        do_flush();
        check("t5_count", 32'(count), 32'd0);
        check("t5_rempty", 32'(rempty), 32'd1);
        check("t5_almost_empty", 32'(almost_empty), 32'd1);
        check("t5_overflow", 32'(overflow), 32'd1);
        check("t5_underflow", 32'(underflow), 32'd1);
        cycle(1'b1, 32'd33, 1'b0);
        cycle(1'b0, '0, 1'b1);

        // Registered-read instance
        rst0 = 1'b1;
        tick0();
        rst0 = 1'b0;
        check("t6_reset_rdata", rdata0, 32'h0);
        check("t6_reset_rempty", 32'(rempty0), 32'd1);
        wpush0 = 1'b1; wdata0 = 32'hA5;
        tick0();
        check("t6_no_pull_yet", rdata0, 32'h0);
        rpull0 = 1'b1;
        tick0();
        check("t6_rdata_a5", rdata0, 32'hA5);
        check("t6_count0", 32'(count0), 32'd0);
        wpush0 = 1'b1; wdata0 = 32'h5A;
        tick0();
        check("t6_hold1", rdata0, 32'hA5);
        tick0();
        check("t6_hold2", rdata0, 32'hA5);
        rpull0 = 1'b1;
        tick0();
        check("t6_rdata_5a", rdata0, 32'h5A);
        rpull0 = 1'b1;
        tick0();
        check("t6_underflow", 32'(underflow0), 32'd1);
        check("t6_rdata_kept", rdata0, 32'h5A);
        for (int i = 0; i < 3; i++) begin
            wpush0 = 1'b1; wdata0 = 32'(200 + i);
            tick0();
        end
        check("t6_pre_rst_count", 32'(count0), 32'd3);
        rst0 = 1'b1; wpush0 = 1'b1; wdata0 = 32'h77; rpull0 = 1'b1;
        tick0();
        rst0 = 1'b0;
        check("t6_rst_count", 32'(count0), 32'd0);
        check("t6_rst_rempty", 32'(rempty0), 32'd1);
        check("t6_rst_wfull", 32'(wfull0), 32'd0);
        check("t6_rst_aempty", 32'(almost_empty0), 32'd1);
        check("t6_rst_afull", 32'(almost_full0), 32'd0);
        check("t6_rst_overflow", 32'(overflow0), 32'd0);
        check("t6_rst_underflow", 32'(underflow0), 32'd0);
        check("t6_rst_rdata", rdata0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
